// File: rtl/pw_pkg.sv
// Shared types and constants for the pointwise-conv activation reader.
package pw_pkg;

  localparam int STRIDE_W  = 2;
  localparam int PW_DIM_W  = 16;
  localparam int PW_IC_PAR = 8;

  // Side-band that travels with each read through the latency pipe and the FIFO.
  typedef struct packed {
    logic [PW_IC_PAR-1:0] mask;
    logic                 first;
    logic                 last;
    logic [PW_DIM_W-1:0]  ch_idx;
  } pw_beat_tag_t;

  function automatic logic [PW_IC_PAR-1:0] lane_mask(input logic [PW_DIM_W:0] remaining);
    logic [PW_IC_PAR-1:0] m;
    m = '0;
    for (int i = 0; i < PW_IC_PAR; i++) begin
      m[i] = (remaining > (PW_DIM_W + 1)'(i));
    end
    return m;
  endfunction

endpackage

// File: rtl/pw_tile_reader_pipe_sync_fifo.sv
// Small synchronous FIFO; the head is read straight from storage registers.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push, w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != (PTR_W + 1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/pw_tile_reader_pipe.sv
// Pointwise-conv activation reader: walks row/col/channel-group, issues lane reads,
// realigns returning data with its tag and buffers it in a credit-limited FIFO.
module pw_tile_reader_pipe
  import pw_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = PW_DIM_W,
  parameter int IC_PAR     = PW_IC_PAR,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [DIM_W-1:0]           cfg_in_h,
  input  logic [DIM_W-1:0]           cfg_in_w,
  input  logic [DIM_W-1:0]           cfg_out_h,
  input  logic [DIM_W-1:0]           cfg_out_w,
  input  logic [STRIDE_W-1:0]        cfg_stride,
  input  logic [DIM_W-1:0]           cfg_ch_start,
  input  logic [DIM_W-1:0]           cfg_ch_count,
  input  logic [ADDR_W-1:0]          cfg_base_addr,
  output logic [IC_PAR-1:0]          rd_en,
  output logic [IC_PAR*ADDR_W-1:0]   rd_addr_vec,
  input  logic [IC_PAR*DATA_W-1:0]   rd_data_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IC_PAR*DATA_W-1:0]   out_data_vec,
  output logic [IC_PAR-1:0]          out_lane_mask,
  output logic                       out_first_ch,
  output logic                       out_last_ch,
  output logic [DIM_W-1:0]           out_in_ch_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int TAG_W  = $bits(pw_beat_tag_t);
  localparam int DVEC_W = IC_PAR * DATA_W;
  localparam int ENT_W  = DVEC_W + TAG_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
  state_t r_state, w_state_next;

  logic [DIM_W-1:0]         r_out_h, r_out_w, r_ch_start, r_ch_count;
  logic                     r_stride2, r_degen;
  logic [ADDR_W-1:0]        r_ch_base, r_grp_step, r_row_step;
  logic [ADDR_W-1:0]        r_lane_off [IC_PAR];
  logic [DIM_W-1:0]         r_g, r_c, r_r;
  logic [ADDR_W-1:0]        r_ch_addr, r_row_off, r_col_off;
  logic [CRED_W-1:0]        r_credits;
  logic [IC_PAR-1:0]        r_rd_en;
  logic [IC_PAR*ADDR_W-1:0] r_rd_addr;
  logic                     r_iss_valid;
  pw_beat_tag_t             r_iss_tag;
  logic [RD_LAT-1:0]        r_tag_v;
  pw_beat_tag_t             r_tag [RD_LAT];

  logic                     w_start_go, w_issue, w_pop, w_push, w_fifo_valid, w_done;
  logic                     w_last_grp, w_last_col, w_last_row, w_walk_end;
  logic [DIM_W:0]           w_remaining;
  logic [IC_PAR-1:0]        w_mask;
  logic [ADDR_W-1:0]        w_plane, w_ch_base, w_pix_addr;
  logic [ADDR_W-1:0]        w_lane_off_init [IC_PAR];
  logic [IC_PAR*ADDR_W-1:0] w_lane_addr;
  logic [DVEC_W-1:0]        w_wr_data, w_head_data;
  logic [ENT_W-1:0]         w_head;
  pw_beat_tag_t             w_iss_tag, w_tail, w_head_tag;

  // All multiplies act on cfg inputs at start; the issue path only adds.
  assign w_plane    = ADDR_W'(cfg_in_h) * ADDR_W'(cfg_in_w);
  assign w_ch_base  = cfg_base_addr + ADDR_W'(cfg_ch_start) * w_plane;
  assign w_start_go = (r_state == S_IDLE) && start && !abort;
  assign w_issue    = (r_state == S_ISSUE) && !r_degen && (r_credits != '0);

  assign w_remaining = {1'b0, r_ch_count} - {1'b0, r_g};
  assign w_mask      = lane_mask(w_remaining);
  assign w_last_grp  = ({1'b0, r_g} + (DIM_W + 1)'(IC_PAR)) >= {1'b0, r_ch_count};
  assign w_last_col  = (r_c == r_out_w - 1'b1);
  assign w_last_row  = (r_r == r_out_h - 1'b1);
  assign w_walk_end  = w_last_grp && w_last_col && w_last_row;
  assign w_pix_addr  = r_ch_addr + r_row_off + r_col_off;

  assign w_iss_tag.mask   = w_mask;
  assign w_iss_tag.first  = (r_g == '0);
  assign w_iss_tag.last   = w_last_grp;
  assign w_iss_tag.ch_idx = r_ch_start + r_g;

  assign w_tail = r_tag[RD_LAT-1];
  assign w_push = r_tag_v[RD_LAT-1];

  genvar gi;
  generate
    for (gi = 0; gi < IC_PAR; gi++) begin : g_lane
      assign w_lane_off_init[gi] = ADDR_W'(gi) * w_plane;
      assign w_lane_addr[gi*ADDR_W +: ADDR_W] =
        w_mask[gi] ? (w_pix_addr + r_lane_off[gi]) : '0;
      assign w_wr_data[gi*DATA_W +: DATA_W] =
        w_tail.mask[gi] ? rd_data_vec[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = S_ISSUE;
      S_ISSUE: if (r_degen || (w_issue && w_walk_end)) w_state_next = S_DRAIN;
      S_DRAIN: if (!w_fifo_valid && !r_iss_valid && (r_tag_v == '0)) begin
                 w_state_next = S_IDLE;
                 w_done       = 1'b1;
               end
      default: w_state_next = S_IDLE;
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
      w_done       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_h <= '0; r_out_w <= '0; r_ch_start <= '0; r_ch_count <= '0;
      r_stride2 <= 1'b0; r_degen <= 1'b0;
      r_ch_base <= '0; r_grp_step <= '0; r_row_step <= '0;
      r_g <= '0; r_c <= '0; r_r <= '0;
      r_ch_addr <= '0; r_row_off <= '0; r_col_off <= '0;
      for (int k = 0; k < IC_PAR; k++) r_lane_off[k] <= '0;
    end else if (w_start_go) begin
      r_out_h    <= cfg_out_h;
      r_out_w    <= cfg_out_w;
      r_ch_start <= cfg_ch_start;
      r_ch_count <= cfg_ch_count;
      r_stride2  <= (cfg_stride == 2'd2);
      r_degen    <= (cfg_out_h == '0) || (cfg_out_w == '0) || (cfg_ch_count == '0);
      r_ch_base  <= w_ch_base;
      r_grp_step <= ADDR_W'(IC_PAR) * w_plane;
      r_row_step <= (cfg_stride == 2'd2) ? (ADDR_W'(cfg_in_w) << 1) : ADDR_W'(cfg_in_w);
      for (int k = 0; k < IC_PAR; k++) r_lane_off[k] <= w_lane_off_init[k];
      r_g <= '0; r_c <= '0; r_r <= '0;
      r_ch_addr <= w_ch_base; r_row_off <= '0; r_col_off <= '0;
    end else if (w_issue) begin
      if (!w_last_grp) begin
        r_g       <= r_g + DIM_W'(IC_PAR);
        r_ch_addr <= r_ch_addr + r_grp_step;
      end else begin
        r_g       <= '0;
        r_ch_addr <= r_ch_base;
        if (!w_last_col) begin
          r_c       <= r_c + 1'b1;
          r_col_off <= r_col_off + (r_stride2 ? ADDR_W'(2) : ADDR_W'(1));
        end else begin
          r_c       <= '0;
          r_col_off <= '0;
          r_r       <= r_r + 1'b1;
          r_row_off <= r_row_off + r_row_step;
        end
      end
    end
  end

  // Credits cover FIFO slots plus every read still travelling through the tag pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_credits <= CRED_W'(FIFO_DEPTH);
    else if (abort) r_credits <= CRED_W'(FIFO_DEPTH);
    else begin
      case ({w_issue, w_pop})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01:   r_credits <= r_credits + 1'b1;
        default: r_credits <= r_credits;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || abort) begin
      r_iss_valid <= 1'b0;
      r_rd_en     <= '0;
      r_rd_addr   <= '0;
      r_iss_tag   <= '0;
      r_tag_v     <= '0;
      for (int k = 0; k < RD_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_iss_valid <= w_issue;
      r_rd_en     <= w_issue ? w_mask : '0;
      r_rd_addr   <= w_issue ? w_lane_addr : '0;
      r_iss_tag   <= w_iss_tag;
      r_tag_v[0]  <= r_iss_valid;
      r_tag[0]    <= r_iss_tag;
      for (int k = 1; k < RD_LAT; k++) begin
        r_tag_v[k] <= r_tag_v[k-1];
        r_tag[k]   <= r_tag[k-1];
      end
    end
  end

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (abort),
    .i_push  (w_push),
    .i_data  ({w_wr_data, w_tail}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid)
  );

  assign w_pop       = w_fifo_valid && out_ready;
  assign w_head_data = w_head[ENT_W-1:TAG_W];
  assign w_head_tag  = pw_beat_tag_t'(w_head[TAG_W-1:0]);

  assign rd_en         = r_rd_en;
  assign rd_addr_vec   = r_rd_addr;
  assign out_valid     = w_fifo_valid;
  assign out_data_vec  = w_fifo_valid ? w_head_data : '0;
  assign out_lane_mask = w_fifo_valid ? w_head_tag.mask : '0;
  assign out_first_ch  = w_fifo_valid && w_head_tag.first;
  assign out_last_ch   = w_fifo_valid && w_head_tag.last;
  assign out_in_ch_idx = w_fifo_valid ? w_head_tag.ch_idx : '0;
  assign busy          = (r_state != S_IDLE);
  assign done          = w_done;

endmodule

// File: tb/tb_pw_tile_reader_pipe.sv
// Directed bench for pw_tile_reader_pipe with a latency-accurate SRAM model.
module tb_pw_tile_reader_pipe;

  localparam int DATA_W = 8, ADDR_W = 32, DIM_W = 16, IC_PAR = 8;
  localparam int RD_LAT = 3, FIFO_DEPTH = 4;
  localparam int TMO = 600;

  logic clk, rst, start, abort, out_ready;
  logic [DIM_W-1:0] cfg_in_h, cfg_in_w, cfg_out_h, cfg_out_w, cfg_ch_start, cfg_ch_count;
  logic [1:0] cfg_stride;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [IC_PAR-1:0] rd_en, out_lane_mask;
  logic [IC_PAR*ADDR_W-1:0] rd_addr_vec;
  logic [IC_PAR*DATA_W-1:0] rd_data_vec, out_data_vec;
  logic out_valid, out_first_ch, out_last_ch, busy, done;
  logic [DIM_W-1:0] out_in_ch_idx;

  pw_tile_reader_pipe #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .IC_PAR(IC_PAR),
    .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_out_h(cfg_out_h), .cfg_out_w(cfg_out_w),
    .cfg_stride(cfg_stride), .cfg_ch_start(cfg_ch_start), .cfg_ch_count(cfg_ch_count),
    .cfg_base_addr(cfg_base_addr), .rd_en(rd_en), .rd_addr_vec(rd_addr_vec),
    .rd_data_vec(rd_data_vec), .out_valid(out_valid), .out_ready(out_ready),
    .out_data_vec(out_data_vec), .out_lane_mask(out_lane_mask), .out_first_ch(out_first_ch),
    .out_last_ch(out_last_ch), .out_in_ch_idx(out_in_ch_idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // SRAM model: data appears RD_LAT cycles after rd_en; unread lanes return junk.
  logic [IC_PAR-1:0]        m_en   [RD_LAT];
  logic [IC_PAR*ADDR_W-1:0] m_addr [RD_LAT];
  always @(posedge clk) begin
    m_en[0]   <= rd_en;
    m_addr[0] <= rd_addr_vec;
    for (int k = 1; k < RD_LAT; k++) begin
      m_en[k]   <= m_en[k-1];
      m_addr[k] <= m_addr[k-1];
    end
  end
  always_comb begin
    rd_data_vec = '0;
    for (int i = 0; i < IC_PAR; i++)
      rd_data_vec[i*DATA_W +: DATA_W] = m_en[RD_LAT-1][i] ?
        mem_val(m_addr[RD_LAT-1][i*ADDR_W +: ADDR_W]) : 8'hEE;
  end

  typedef struct {
    logic [63:0]  data;
    logic [7:0]   mask;
    logic         first;
    logic         last;
    logic [15:0]  ch;
    logic [255:0] addr;
  } beat_t;

  beat_t exp_q[$];
  logic [31:0] obs_lane0[$], obs_lane1[$];
  logic [7:0]  obs_mask[$];
  logic [15:0] obs_ch[$];
  logic [63:0] obs_data[$];
  int n_cmp = 0, n_mis = 0;
  int n_iss, n_pop, first_valid_n, done_n, done_cnt, last_pop_n, max_outst;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_walk(input int in_h, input int in_w, input int out_h, input int out_w,
                          input int stride, input int ch_start, input int ch_count,
                          input logic [31:0] base, input int stall_at, input int stall_len,
                          input string name);
    int s, plane, n;
    logic [31:0] a;
    beat_t b;
    exp_q.delete(); obs_lane0.delete(); obs_lane1.delete();
    obs_mask.delete(); obs_ch.delete(); obs_data.delete();
    s = (stride == 2) ? 2 : 1;
    plane = in_h * in_w;
    for (int r = 0; r < out_h; r++)
      for (int c = 0; c < out_w; c++)
        for (int g = 0; g < ch_count; g += IC_PAR) begin
          b.mask = '0; b.addr = '0; b.data = '0;
          for (int i = 0; i < IC_PAR; i++)
            if (g + i < ch_count) begin
              a = base + (ch_start + g + i) * plane + r * s * in_w + c * s;
              b.mask[i] = 1'b1;
              b.addr[i*32 +: 32] = a;
              b.data[i*8 +: 8] = mem_val(a);
            end
          b.first = (g == 0);
          b.last  = (g + IC_PAR >= ch_count);
          b.ch    = 16'(ch_start + g);
          exp_q.push_back(b);
        end
    n_iss = 0; n_pop = 0; first_valid_n = -1; done_n = -1; done_cnt = 0;
    last_pop_n = -1; max_outst = 0;
    @(negedge clk);
    cfg_in_h = 16'(in_h); cfg_in_w = 16'(in_w); cfg_out_h = 16'(out_h); cfg_out_w = 16'(out_w);
    cfg_stride = 2'(stride); cfg_ch_start = 16'(ch_start); cfg_ch_count = 16'(ch_count);
    cfg_base_addr = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < TMO) begin
      if (n == 0) chk({name, "_busy_up"}, busy, 1);
      if (rd_en != '0) begin
        if (n_iss < exp_q.size()) begin
          chk({name, "_rd_addr"}, rd_addr_vec, exp_q[n_iss].addr);
          chk({name, "_rd_en"}, rd_en, exp_q[n_iss].mask);
        end else chk({name, "_extra_issue"}, n_iss + 1, exp_q.size());
        obs_lane0.push_back(rd_addr_vec[31:0]);
        obs_lane1.push_back(rd_addr_vec[63:32]);
        n_iss++;
      end
      if (out_valid && first_valid_n < 0) first_valid_n = n;
      if (out_valid && out_ready) begin
        if (n_pop < exp_q.size()) begin
          chk({name, "_data"}, out_data_vec, exp_q[n_pop].data);
          chk({name, "_mask"}, out_lane_mask, exp_q[n_pop].mask);
          chk({name, "_first_last"}, {out_first_ch, out_last_ch},
              {exp_q[n_pop].first, exp_q[n_pop].last});
          chk({name, "_ch_idx"}, out_in_ch_idx, exp_q[n_pop].ch);
        end else chk({name, "_extra_beat"}, n_pop + 1, exp_q.size());
        obs_mask.push_back(out_lane_mask);
        obs_ch.push_back(out_in_ch_idx);
        obs_data.push_back(out_data_vec);
        last_pop_n = n;
        n_pop++;
      end
      if (n_iss - n_pop > max_outst) max_outst = n_iss - n_pop;
      if (done) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (done_n >= 0 && n == done_n + 1) begin
        chk({name, "_busy_after_done"}, busy, 0);
        break;
      end
      out_ready = !((n + 1 >= stall_at) && (n + 1 < stall_at + stall_len));
      @(negedge clk);
      n++;
    end
    out_ready = 1'b1;
    chk({name, "_n_issue"}, n_iss, exp_q.size());
    chk({name, "_n_beats"}, n_pop, exp_q.size());
    chk({name, "_done_cnt"}, done_cnt, 1);
    if (exp_q.size() > 0) begin
      chk({name, "_latency"}, first_valid_n, RD_LAT + 2);
      chk({name, "_done_time"}, done_n, last_pop_n + 1);
    end else begin
      chk({name, "_done_time"}, done_n, 1);
    end
    $display("walk %s: issues=%0d beats=%0d done_at=%0d max_outstanding=%0d",
             name, n_iss, n_pop, done_n, max_outst);
  endtask

  initial begin
    int seen_done, seen_valid;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cfg_in_h = '0; cfg_in_w = '0; cfg_out_h = '0; cfg_out_w = '0; cfg_stride = '0;
    cfg_ch_start = '0; cfg_ch_count = '0; cfg_base_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs_a", {rd_en, rd_addr_vec}, '0);
    chk("reset_outs_b", {out_valid, out_data_vec, out_lane_mask, out_first_ch, out_last_ch,
                         out_in_ch_idx, busy, done}, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // 2x2 tile, 16 channels: two groups per pixel, 8 beats.
    run_walk(2, 2, 2, 2, 1, 0, 16, 32'h1000, -100, 0, "t1");
    chk("t1_addr_b0", obs_lane0[0], 32'h1000);
    chk("t1_addr_b1", obs_lane0[1], 32'h1020);
    chk("t1_addr_b2", obs_lane0[2], 32'h1001);
    chk("t1_addr_b6", obs_lane0[6], 32'h1003);

    // Stride 2 over a 4x4 input.
    run_walk(4, 4, 2, 2, 2, 0, 8, 32'h2000, -100, 0, "t2");
    chk("t2_pix0", obs_lane0[0], 32'h2000);
    chk("t2_pix1", obs_lane0[1], 32'h2002);
    chk("t2_pix2", obs_lane0[2], 32'h2008);
    chk("t2_pix3", obs_lane0[3], 32'h200A);
    chk("t2_plane", obs_lane1[0], 32'h2010);

    // Channel sub-range 4..13.
    run_walk(2, 2, 1, 2, 1, 4, 10, 32'h3000, -100, 0, "t3");
    chk("t3_addr0", obs_lane0[0], 32'h3010);
    chk("t3_mask0", obs_mask[0], 8'hFF);
    chk("t3_mask1", obs_mask[1], 8'h03);
    chk("t3_ch0", obs_ch[0], 16'd4);
    chk("t3_ch1", obs_ch[1], 16'd12);
    chk("t3_hi_lanes_zero", obs_data[1][63:16], 48'h0);

    // Consumer stall of 20 cycles mid-walk.
    run_walk(4, 4, 4, 4, 1, 0, 8, 32'h4000, 8, 20, "t4");
    chk("t4_max_outstanding", max_outst, FIFO_DEPTH);

    // Abort three cycles into a walk.
    @(negedge clk);
    cfg_in_h = 16'd2; cfg_in_w = 16'd2; cfg_out_h = 16'd2; cfg_out_w = 16'd2; cfg_stride = 2'd1;
    cfg_ch_start = '0; cfg_ch_count = 16'd16; cfg_base_addr = 32'h5000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    seen_done = done;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    seen_valid = 0;
    repeat (10) begin
      if (done) seen_done = 1;
      if (out_valid) seen_valid = 1;
      @(negedge clk);
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_no_valid", seen_valid, 0);
    $display("abort: busy=%0d done_seen=%0d valid_seen=%0d", busy, seen_done, seen_valid);
    run_walk(2, 2, 2, 2, 1, 0, 16, 32'h1000, -100, 0, "t5");

    // Degenerate configurations.
    run_walk(2, 2, 2, 2, 1, 0, 0, 32'h6000, -100, 0, "t6c");
    run_walk(2, 2, 0, 2, 1, 0, 8, 32'h6000, -100, 0, "t6h");

    // Reset while data is queued.
    @(negedge clk);
    cfg_in_h = 16'd4; cfg_in_w = 16'd4; cfg_out_h = 16'd4; cfg_out_w = 16'd4; cfg_stride = 2'd1;
    cfg_ch_start = '0; cfg_ch_count = 16'd8; cfg_base_addr = 32'h7000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_a", {rd_en, rd_addr_vec}, '0);
    chk("rst_mid_b", {out_valid, out_data_vec, out_lane_mask, out_first_ch, out_last_ch,
                      out_in_ch_idx, busy, done}, '0);
    $display("reset mid-walk: busy=%0d out_valid=%0d", busy, out_valid);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    run_walk(2, 2, 2, 2, 1, 0, 16, 32'h1000, -100, 0, "t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
